// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module   : seq_shift_add_mult
// Brief    : Unsigned shift-add multiplier, WIDTH iterations on one external adder.
// Revision : 1.0 - initial release
// ============================================================================
module seq_shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_product;

    // DONE also samples start so back-to-back products come every WIDTH+1 cycles.
    logic w_accept;
    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_a     <= '0;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    // The carry bit C is always cleared by the shift, so cout lands in A's MSB.
                    r_a   <= {add_cout, add_sum[WIDTH-1:1]};
                    r_q   <= {add_sum[0], r_q[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_product <= {add_cout, add_sum, r_q[WIDTH-1:1]};
                        r_state   <= c_DONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign add_a   = r_a;
    assign add_b   = r_m & {WIDTH{r_q[0]}};
    assign add_cin = 1'b0;
    assign product = r_product;
    assign busy    = (r_state == c_RUN);
    assign done    = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_shift_add_mult
// Brief    : Directed bench with a cycle-level arithmetic model of the multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_shift_add_mult;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] product;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic chk_zero_b = 1'b0;

    seq_shift_add_mult #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    // External ripple-carry adder stand-in.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: phase 0 idle, 1..WIDTH iterating, WIDTH+1 result cycle.
    int          m_phase = 0;
    logic [63:0] m_pend  = '0;
    logic [63:0] m_prod  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_prod  = '0;
        end else if (m_phase == 0 || m_phase == WIDTH + 1) begin
            if (start) begin
                m_pend  = 64'(multiplicand) * 64'(multiplier);
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end else if (m_phase == WIDTH) begin
            m_prod  = m_pend;
            m_phase = WIDTH + 1;
        end else begin
            m_phase = m_phase + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy",    64'(busy),    64'(m_phase >= 1 && m_phase <= WIDTH));
            check("done",    64'(done),    64'(m_phase == WIDTH + 1));
            check("product", product,      m_prod);
            check("add_cin", 64'(add_cin), 64'd0);
            if (chk_zero_b && busy)
                check("add_b_zero", 64'(add_b), 64'd0);
        end
    end

    // Launch at a negedge; returns at the negedge after the accepting edge.
    task automatic do_start(input logic [31:0] m, input logic [31:0] q, output int e0);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        e0           = cyc;
        start        = 1'b0;
        multiplicand = 32'hA5A5_A5A5;
        multiplier   = 32'h5A5A_5A5A;
    endtask

    task automatic wait_done(input string name, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: done timeout got none expected pulse", name);
        end
    endtask

    initial begin
        int e0, at, nb, prev;
        rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        #23;
        check("rst_product", product, 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        check("rst_add", {add_a, add_b}, 64'd0);
        @(negedge clk); #2 rst = 1'b0;

        // 3 x 5: latency, busy length, hold after done
        do_start(32'd3, 32'd5, e0);
        nb = 0; at = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy) nb++;
            if (done) begin at = cyc; break; end
            @(negedge clk);
        end
        check("t1_busy_cycles", 64'(nb), 64'd32);
        check("t1_done_latency", 64'(at - e0), 64'd32);
        check("t1_product", product, 64'h0000_0000_0000_000F);
        repeat (10) @(negedge clk);
        check("t1_hold", product, 64'h0000_0000_0000_000F);

        // all ones: carry out on every iteration
        do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, e0);
        wait_done("t2", at);
        check("t2_product", product, 64'hFFFF_FFFE_0000_0001);

        // zero multiplicand: add_b must stay 0
        chk_zero_b = 1'b1;
        do_start(32'h0, 32'hDEAD_BEEF, e0);
        wait_done("t3", at);
        check("t3_product", product, 64'd0);
        chk_zero_b = 1'b0;

        // start during RUN is ignored
        do_start(32'h0000_1234, 32'h0000_0010, e0);
        repeat (9) @(negedge clk);
        multiplicand = 32'd7; multiplier = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4", at);
        check("t4_product", product, 64'h0000_0000_0001_2340);
        repeat (5) @(negedge clk);

        // reset mid-RUN, then start present at the first edge after release
        do_start(32'hFFFF_FFFF, 32'h0000_0003, e0);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_product", product, 64'd0);
        check("t5_rst_flags", {62'd0, busy, done}, 64'd0);
        check("t5_rst_add", {add_a, add_b, 31'd0, add_cin}, 96'd0);
        @(negedge clk);
        multiplicand = 32'h8000_0000; multiplier = 32'd2; start = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
        wait_done("t5", at);
        check("t5_latency", 64'(at - e0), 64'd32);
        check("t5_product", product, 64'h0000_0001_0000_0000);

        // start held high: one product every WIDTH+1 cycles
        @(negedge clk);
        multiplicand = 32'h1234_5678; multiplier = 32'h9ABC_DEF0; start = 1'b1;
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wait_done("t6", at);
            check("t6_product", product, 64'h0B00_EA4E_242D_2080);
            if (prev >= 0) check("t6_period", 64'(at - prev), 64'd33);
            prev = at;
        end
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
